sd_read_block_buffer: RTL
=========================

// Module: sd_read_block_buffer
// PURPOSE
// Ping-pong block buffer downstream of the SD-card DATA receive path. Captures the 32-bit words
// (Valid/Addr/Data) produced while a block is read from DAT[3:0], holds each block until its CRC
// verdict arrives, then streams only CRC-good blocks to the host side over valid/ready.
// Bad blocks are discarded; overflow is flagged, never silently overwritten.
// PARAMETERS
// BLOCK_WORDS  128  32-bit words per SD block (512 B); power of two, >=4
// ADDR_W       $clog2(BLOCK_WORDS)  word index width within a bank (derived, not overridable)
// PORTS
// clk            in   1   single clock
// rst            in   1   synchronous, active-high reset
// Wr_Valid       in   1   receive-path word strobe (one word per pulse)
// Wr_Addr        in   32  word address from receive path; bank index = Wr_Addr[ADDR_W-1:0]
// Wr_Data        in   32  received word
// Blk_End        in   1   one-cycle pulse: current block's CRC check finished
// Blk_CRC_Fail   in   1   sampled only with Blk_End; 1 = discard block
// Buf_Free       out  1   a bank is FREE or FILLING; controller issues next block read only when 1
// M_Valid        out  1   host word valid
// M_Ready        in   1   host accepts word when M_Valid & M_Ready
// M_Data         out  32  host word
// M_Last         out  1   marks word BLOCK_WORDS-1 of a block
// M_Blk_Num      out  32  block sequence number since reset (good blocks only)
// Overflow       out  1   sticky: Wr_Valid seen with no FILLING/FREE bank; cleared by rst only
// Blk_Dropped    out  1   one-cycle pulse when a block is discarded on CRC fail
// BEHAVIOUR
// - Reset: both banks FREE, write ptr=0, read ptr=0; M_Valid=0, M_Last=0, M_Data=0,
//   M_Blk_Num=0, Overflow=0, Blk_Dropped=0, Buf_Free=1.
// - Per-bank state: FREE -> FILLING (first Wr_Valid) -> FULL (Blk_End, CRC ok) -> DRAINING
//   (read side selects it) -> FREE (handshake on M_Last). FILLING -> FREE on Blk_End with CRC fail.
// - Write side: Wr_Valid writes Wr_Data at Wr_Addr[ADDR_W-1:0] of write bank; bank goes FILLING.
//   Blk_End closes the bank and toggles write ptr (ok) or frees it and keeps ptr (fail, Blk_Dropped=1).
//   Blk_End on a FREE bank (no words) is ignored, no pulse. Word-count mismatch is not checked.
// - Wr_Valid while write bank is FULL/DRAINING: word dropped, Overflow<=1, no state change.
// - Read side: banks drained in fill order. RAM read is synchronous (1 cycle); output is a
//   2-entry skid so M_Valid holds and M_Data is stable while M_Ready=0; full throughput of one
//   word/cycle when M_Ready=1. First word of a FULL bank appears at M_Valid 2 cycles after FULL.
// - M_Last on word BLOCK_WORDS-1; handshake on it frees bank, increments M_Blk_Num (wraps 2^32),
//   toggles read ptr. M_Blk_Num shows the number of the block currently being presented.
// - Simultaneous Blk_End on bank A and last-word handshake on bank B: both take effect same cycle.
// - Simultaneous Wr_Valid and Blk_End: write lands in the closing bank first, then it closes.
// - Buf_Free = write bank is FREE or FILLING (combinational from registered state).
// - rst mid-block: all contents dropped, outputs to reset values next cycle; no partial output.
// STRUCTURE
// - Shared package sd_pkg: typedef enum logic[1:0] {BANK_FREE,BANK_FILLING,BANK_FULL,
//   BANK_DRAINING} bank_state_t; localparam SD_BLOCK_BYTES=512.
// - One sub-module: sd_bank_ram (2*BLOCK_WORDS x 32 simple dual-port, sync write, sync read,
//   address = {bank, index}), inferable as block RAM.
// - Top holds bank state regs, pointers, skid buffer, counters.
// TESTING
// - Fill 128 words data=addr, Blk_End ok, M_Ready=1 -> 128 words 0..127, M_Last on 127, M_Blk_Num=0.
// - Block 0 good, block 1 Blk_CRC_Fail=1, block 2 good -> host sees blocks with data of 0 and 2
//   as M_Blk_Num 0,1; Blk_Dropped pulses once.
// - M_Ready=0 while 2 banks fill -> Buf_Free=0; 3rd block Wr_Valid -> Overflow=1, banks intact,
//   then M_Ready=1 drains both blocks unchanged.
// - M_Ready toggling 1010... -> no word lost or duplicated, M_Data stable while M_Valid&!M_Ready.
// - rst asserted at word 60 of block, then clean block -> only clean block output, M_Blk_Num=0.
// - Blk_End same cycle as last-word handshake of other bank -> both banks transition; no stall.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD-card read data path.
package sd_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int SD_WORD_BYTES  = 4;
  localparam int SD_WORD_W      = SD_WORD_BYTES * 8;

  // Life cycle of one buffer bank.
  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // A bank can take receive-path words only before its block has been closed.
  function automatic logic bank_accepts_write(input bank_state_t s);
    return (s == BANK_FREE) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/sd_bank_ram.sv
// Two-bank word store: simple dual-port RAM, synchronous write and read.
// Address = {bank, word index}.
module sd_bank_ram
  import sd_pkg::*;
#(
  parameter  int BLOCK_WORDS = 128,
  localparam int ADDR_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_W:0]      i_wr_addr,
  input  logic [SD_WORD_W-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_W:0]      i_rd_addr,
  output logic [SD_WORD_W-1:0] o_rd_data
);

  logic [SD_WORD_W-1:0] r_mem [2*BLOCK_WORDS];

  // Write port and registered read port; the two ports always address different banks.
  // NOTE: the array has no reset so it maps onto block RAM; bank state decides which contents are meaningful.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sd_read_block_buffer.sv
// Ping-pong block buffer behind the SD DATA receive path. Holds each block
// until its CRC verdict, discards bad blocks, and streams good blocks to the
// host over valid/ready through a 2-entry skid buffer.
module sd_read_block_buffer
  import sd_pkg::*;
#(
  parameter int BLOCK_WORDS = SD_BLOCK_BYTES / SD_WORD_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Wr_Valid,
  input  logic [31:0] Wr_Addr,
  input  logic [31:0] Wr_Data,
  input  logic        Blk_End,
  input  logic        Blk_CRC_Fail,
  output logic        Buf_Free,
  output logic        M_Valid,
  input  logic        M_Ready,
  output logic [31:0] M_Data,
  output logic        M_Last,
  output logic [31:0] M_Blk_Num,
  output logic        Overflow,
  output logic        Blk_Dropped
);

  localparam int                ADDR_W   = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLOCK_WORDS - 1);

  // Bank bookkeeping
  bank_state_t r_bank_st [2];
  bank_state_t w_bank_nxt [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;

  // Read issue side
  logic              r_rd_active;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_q_valid;
  logic              r_q_last;
  logic [31:0]       w_q_data;

  // Skid buffer, entry 0 is the head presented to the host
  logic [1:0]  r_sk_cnt;
  logic [31:0] r_sk_data [2];
  logic        r_sk_last [2];

  logic [31:0] r_blk_num;
  logic        r_overflow;
  logic        r_blk_dropped;

  // Write-side decode
  bank_state_t w_wr_st;
  logic        w_wr_ok;
  logic        w_wr_reject;
  logic        w_close;
  logic        w_close_good;
  logic        w_close_bad;

  // Read-side decode
  bank_state_t w_rd_st;
  logic        w_rd_sel;
  logic        w_pop;
  logic        w_pop_last;
  logic [2:0]  w_occ;
  logic        w_can_issue;
  logic        w_issue;

  // Only the in-bank index of the receive address matters.
  logic w_unused_addr;
  assign w_unused_addr = ^Wr_Addr[31:ADDR_W];

  assign w_wr_st      = r_bank_st[r_wr_ptr];
  assign w_wr_ok      = Wr_Valid && bank_accepts_write(w_wr_st);
  assign w_wr_reject  = Wr_Valid && !bank_accepts_write(w_wr_st);
  // A word arriving with Blk_End lands first, so an empty bank written this cycle still closes.
  assign w_close      = Blk_End && ((w_wr_st == BANK_FILLING) || w_wr_ok);
  assign w_close_good = w_close && !Blk_CRC_Fail;
  assign w_close_bad  = w_close && Blk_CRC_Fail;

  assign w_rd_st     = r_bank_st[r_rd_ptr];
  assign w_rd_sel    = !r_rd_active && (w_rd_st == BANK_FULL);
  assign w_pop       = M_Valid && M_Ready;
  assign w_pop_last  = w_pop && r_sk_last[0];
  // Issue a RAM read only if the skid buffer can still take it once it returns.
  assign w_occ       = {1'b0, r_sk_cnt} + {2'b00, r_q_valid};
  assign w_can_issue = (w_occ - {2'b00, w_pop}) <= 3'd1;
  assign w_issue     = w_can_issue && (r_rd_active || w_rd_sel);

  sd_bank_ram #(.BLOCK_WORDS(BLOCK_WORDS)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr ({r_wr_ptr, Wr_Addr[ADDR_W-1:0]}),
    .i_wr_data (Wr_Data),
    .i_rd_en   (w_issue),
    .i_rd_addr ({r_rd_ptr, r_rd_idx}),
    .o_rd_data (w_q_data)
  );

  // Next bank states; write and read sides only ever act on disjoint states.
  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    w_bank_nxt[0] = r_bank_st[0];
    w_bank_nxt[1] = r_bank_st[1];
    if (w_wr_ok)           w_bank_nxt[r_wr_ptr] = BANK_FILLING;
    if (w_close_good)      w_bank_nxt[r_wr_ptr] = BANK_FULL;
    else if (w_close_bad)  w_bank_nxt[r_wr_ptr] = BANK_FREE;
    if (w_rd_sel)          w_bank_nxt[r_rd_ptr] = BANK_DRAINING;
    if (w_pop_last)        w_bank_nxt[r_rd_ptr] = BANK_FREE;
  end

  // Bank state, pointers and status flags.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_st[0]  <= BANK_FREE;
      r_bank_st[1]  <= BANK_FREE;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_overflow    <= 1'b0;
      r_blk_dropped <= 1'b0;
    end else begin
      r_bank_st[0]  <= w_bank_nxt[0];
      r_bank_st[1]  <= w_bank_nxt[1];
      if (w_close_good) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_last)   r_rd_ptr <= ~r_rd_ptr;
      if (w_wr_reject)  r_overflow <= 1'b1;
      r_blk_dropped <= w_close_bad;
    end
  end

  // Walk the word index of the draining bank and track reads in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_active <= 1'b0;
      r_rd_idx    <= '0;
      r_q_valid   <= 1'b0;
      r_q_last    <= 1'b0;
    end else begin
      r_q_valid <= w_issue;
      r_q_last  <= w_issue && (r_rd_idx == LAST_IDX);
      if (w_issue) begin
        r_rd_idx    <= r_rd_idx + 1'b1;
        r_rd_active <= (r_rd_idx != LAST_IDX);
      end else if (w_rd_sel) begin
        r_rd_active <= 1'b1;
      end
    end
  end

  // Skid buffer: push returning RAM words, pop on host handshake; count blocks delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sk_cnt     <= 2'd0;
      r_sk_data[0] <= '0;
      r_sk_data[1] <= '0;
      r_sk_last[0] <= 1'b0;
      r_sk_last[1] <= 1'b0;
      r_blk_num    <= '0;
    end else begin
      if (w_pop_last) r_blk_num <= r_blk_num + 32'd1;
      case ({r_q_valid, w_pop})
        2'b10: begin
          if (r_sk_cnt == 2'd0) begin
            r_sk_data[0] <= w_q_data;
            r_sk_last[0] <= r_q_last;
          end else begin
            r_sk_data[1] <= w_q_data;
            r_sk_last[1] <= r_q_last;
          end
          r_sk_cnt <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_data[0] <= r_sk_data[1];
          r_sk_last[0] <= r_sk_last[1];
          r_sk_cnt     <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          if (r_sk_cnt == 2'd1) begin
            r_sk_data[0] <= w_q_data;
            r_sk_last[0] <= r_q_last;
          end else begin
            r_sk_data[0] <= r_sk_data[1];
            r_sk_last[0] <= r_sk_last[1];
            r_sk_data[1] <= w_q_data;
            r_sk_last[1] <= r_q_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign Buf_Free    = bank_accepts_write(w_wr_st);
  assign M_Valid     = (r_sk_cnt != 2'd0);
  assign M_Data      = r_sk_data[0];
  assign M_Last      = M_Valid && r_sk_last[0];
  assign M_Blk_Num   = r_blk_num;
  assign Overflow    = r_overflow;
  assign Blk_Dropped = r_blk_dropped;

endmodule
